// File: rtl/multi_channel_read_buffer.sv
// Captures read_count serial bits from NUM_CH lines in lockstep. Each bit is taken on a read_sig strobe.
// Bits are stored MSB- or LSB-first. A capture ends normally when all bits are read, or early on abort or idle timeout.
module multi_channel_read_buffer #(
  parameter int BUF_SIZE       = 8,
  parameter int NUM_CH         = 2,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int CTR_SIZE      = $clog2(BUF_SIZE + 1)
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       lsb_first,
  input  logic                       read_sig,
  input  logic [NUM_CH-1:0]          data_in,
  input  logic [CTR_SIZE-1:0]        read_count,
  output logic [NUM_CH*BUF_SIZE-1:0] data_out,
  output logic [CTR_SIZE-1:0]        bits_read,
  output logic                       busy,
  output logic                       done_sig,
  output logic                       timeout_flag,
  output logic                       abort_flag
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CTR_SIZE-1:0] BUF_MAX = CTR_SIZE'(BUF_SIZE);
  localparam logic [TW-1:0]       T_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]       T_SAT   = '1;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_IDLE  = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t                     state, state_next;
  logic [CTR_SIZE-1:0]        remaining;
  logic [TW-1:0]              tcnt;
  logic                       lsb_q;
  logic [NUM_CH*BUF_SIZE-1:0] data_cap;

  logic do_clear, do_start, do_finish, do_abort, do_timeout;
  logic do_capture, do_tick, do_illegal;

  always_comb begin
    state_next = S_RESET;
    do_clear   = 1'b0;
    do_start   = 1'b0;
    do_finish  = 1'b0;
    do_abort   = 1'b0;
    do_timeout = 1'b0;
    do_capture = 1'b0;
    do_tick    = 1'b0;
    do_illegal = 1'b0;
    case (state)
      S_RESET: begin
        do_clear   = 1'b1;
        state_next = S_IDLE;
      end
      S_IDLE: begin
        state_next = S_IDLE;
        if (start) begin
          do_start   = 1'b1;
          state_next = S_READ;
        end
      end
      S_READ: begin
        state_next = S_READ;
        if (abort) begin
          do_abort   = 1'b1;
          do_finish  = 1'b1;
          state_next = S_IDLE;
        end else if (remaining == '0) begin
          do_finish  = 1'b1;
          state_next = S_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (tcnt == T_LIMIT)) begin
          do_timeout = 1'b1;
          do_finish  = 1'b1;
          state_next = S_IDLE;
        end else if (read_sig) begin
          do_capture = 1'b1;
        end else begin
          do_tick = 1'b1;
        end
      end
      default: begin
        do_illegal = 1'b1;
        state_next = S_RESET;
      end
    endcase
  end

  // LSB-first writes are matched against every in-range bit position, so no write can leave its slice.
  always_comb begin
    data_cap = data_out;
    for (int c = 0; c < NUM_CH; c++) begin
      if (lsb_q) begin
        for (int b = 0; b < BUF_SIZE; b++) begin
          if (bits_read == CTR_SIZE'(b)) data_cap[c*BUF_SIZE + b] = data_in[c];
        end
      end else begin
        data_cap[c*BUF_SIZE +: BUF_SIZE] = {data_out[c*BUF_SIZE +: BUF_SIZE-1], data_in[c]};
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= S_RESET;
      data_out     <= '0;
      bits_read    <= '0;
      remaining    <= '0;
      lsb_q        <= 1'b0;
      tcnt         <= '0;
      done_sig     <= 1'b0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
      abort_flag   <= 1'b0;
    end else begin
      state <= state_next;
      if (do_clear || do_start) begin
        data_out     <= '0;
        bits_read    <= '0;
        tcnt         <= '0;
        timeout_flag <= 1'b0;
        abort_flag   <= 1'b0;
      end
      if (do_clear) begin
        done_sig <= 1'b1;
        busy     <= 1'b0;
      end
      if (do_start) begin
        lsb_q     <= lsb_first;
        remaining <= (read_count > BUF_MAX) ? BUF_MAX : read_count;
        done_sig  <= 1'b0;
        busy      <= 1'b1;
      end
      if (do_finish) begin
        done_sig <= 1'b1;
        busy     <= 1'b0;
      end
      if (do_abort)   abort_flag   <= 1'b1;
      if (do_timeout) timeout_flag <= 1'b1;
      if (do_capture) begin
        data_out  <= data_cap;
        remaining <= remaining - CTR_SIZE'(1);
        bits_read <= bits_read + CTR_SIZE'(1);
        tcnt      <= '0;
      end
      if (do_tick && (tcnt != T_SAT)) tcnt <= tcnt + TW'(1);
      if (do_illegal) begin
        done_sig <= 1'b0;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: doc/multi_channel_read_buffer.md
MULTI_CHANNEL_READ_BUFFER -- requirements
Module: multi_channel_read_buffer

Interface
REQ-001 The block SHALL have the following parameters, one per line.
- BUF_SIZE, default 8: maximum bits buffered per channel (>=2).
- NUM_CH, default 2: number of independent serial lines sampled in lockstep (>=1).
- TIMEOUT_CYCLES, default 0: maximum idle sys_clk cycles between read_sig pulses; 0 disables the timeout.
REQ-002 CTR_SIZE SHALL be a localparam equal to ceil(log2(BUF_SIZE+1)).
REQ-003 The block SHALL have the following ports, one per line.
- sys_clk  in  1: system clock, all logic on its rising edge.
- rst  in  1: reset, synchronous, active-high.
- start  in  1: one-cycle request to begin a capture.
- abort  in  1: terminate an active capture early.
- lsb_first  in  1: bit order, sampled with start.
- read_sig  in  1: sample strobe, synchronous to sys_clk, one cycle per bit.
- data_in  in  NUM_CH: serial data, bit c is channel c.
- read_count  in  CTR_SIZE: bits to capture, sampled with start.
- data_out  out  NUM_CH*BUF_SIZE: channel c occupies bits [c*BUF_SIZE +: BUF_SIZE].
- bits_read  out  CTR_SIZE: bits captured so far in the current or last capture.
- busy  out  1: high while in READ.
- done_sig  out  1: high when the block is idle and results are valid.
- timeout_flag  out  1: last capture ended by timeout.
- abort_flag  out  1: last capture ended by abort.

Function
REQ-004 The FSM SHALL have exactly three states: RESET, IDLE and READ; any other encoding SHALL go to RESET with done_sig=0.
REQ-005 RESET SHALL, in one cycle, clear data_out, bits_read and both flags, set done_sig=1 and go to IDLE.
REQ-006 In IDLE, start=1 SHALL do the following on the same edge:
- clear data_out, bits_read and both flags;
- latch lsb_first;
- load remaining = min(read_count, BUF_SIZE);
- set done_sig=0 and busy=1;
- go to READ.
REQ-007 In IDLE, read_sig and abort SHALL be ignored, and data_out SHALL hold its value.
REQ-008 In READ, the first true condition in this list SHALL apply each cycle.
- abort: set abort_flag, done_sig=1, busy=0, go to IDLE.
- remaining==0: set done_sig=1, busy=0, go to IDLE.
- Timeout counter == TIMEOUT_CYCLES and TIMEOUT_CYCLES != 0: set timeout_flag, done_sig=1, busy=0, go to IDLE.
- read_sig: capture one bit on every channel, decrement remaining, increment bits_read, clear the timeout counter.
- Otherwise: increment the timeout counter.
REQ-009 MSB-first capture (lsb_first=0) SHALL shift each channel left, inserting data_in[c] at bit 0, so the last bit read is the LSB.
REQ-010 LSB-first capture (lsb_first=1) SHALL write data_in[c] to bit bits_read of channel c, so the first bit read is bit 0 and unwritten bits stay 0.
REQ-011 After n bits, the result SHALL occupy the n least-significant bits of each channel slice, and the upper bits SHALL be 0.
REQ-012 done_sig SHALL rise exactly one cycle after the edge that captured the final bit.
REQ-013 read_count==0 SHALL complete with done_sig=1 two cycles after start, with data_out all zero.
REQ-014 read_count>BUF_SIZE SHALL be clamped to BUF_SIZE, and no bit SHALL ever be written outside its channel slice.
REQ-015 A start seen in READ SHALL be ignored.
REQ-016 A start seen on the same edge that READ returns to IDLE SHALL be ignored; start is accepted only in IDLE.
REQ-017 The timeout counter SHALL saturate and SHALL be cleared on start.
REQ-018 When TIMEOUT_CYCLES=0, the timeout counter SHALL have no effect.
REQ-019 On early termination (abort or timeout), data_out and bits_read SHALL hold the partial capture.

Reset
REQ-020 While rst=1, on every edge the block SHALL:
- set done_sig=0 and busy=0;
- clear the timeout counter;
- enter RESET, overriding start, abort and read_sig.
REQ-021 Reset asserted mid-capture SHALL discard the capture.
REQ-022 Reset release SHALL give done_sig=1 and cleared outputs one cycle after the first edge with rst=0.
REQ-023 Power-up register values SHALL equal the values RESET produces, with state=RESET.

Verification
REQ-024 NUM_CH=2, MSB-first, read_count=8, ch0 stream 1,0,1,1,0,0,1,0 and ch1 stream 0xFF, read_sig every 3rd cycle: ch0=0xB2, ch1=0xFF, bits_read=8, done_sig one cycle after the 8th strobe.
REQ-025 LSB-first, read_count=5, ch0 stream 1,1,0,0,1: ch0=0x13, bits 7:5=0.
REQ-026 read_count=12 with BUF_SIZE=8: exactly 8 bits captured, bits_read=8, no corruption of ch1.
REQ-027 TIMEOUT_CYCLES=4, read_count=6, strobes stop after 3 bits: timeout_flag=1, bits_read=3, partial data retained.
REQ-028 abort after 2 bits: abort_flag=1, done_sig=1 next cycle, then a new start is accepted.
REQ-029 rst pulsed mid-capture: done_sig=0 while rst=1, then 1 with all outputs zero.
